// File: rtl/pixel_pkg.sv
// Shared types, geometry and address packing for the pixel memory controller.
package pixel_pkg;

    localparam int unsigned IMG_W  = 32;
    localparam int unsigned IMG_H  = 32;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned K      = 3;
    localparam int unsigned OUT_W  = IMG_W - K + 1;
    localparam int unsigned OUT_H  = IMG_H - K + 1;

    localparam int unsigned COL_W  = 5;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned KOFF_W = 2;
    localparam int unsigned TAP_W  = 4;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    localparam int unsigned CH_LSB  = 10;
    localparam int unsigned ROW_LSB = 5;

    localparam logic [CH_W-1:0] RED   = 2'b00;
    localparam logic [CH_W-1:0] GREEN = 2'b01;
    localparam logic [CH_W-1:0] BLUE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CONV
    } state_t;

    // Sideband that travels with each tap through the read-latency stage.
    typedef struct packed {
        logic [TAP_W-1:0] tap_idx;
        logic [ROW_W-1:0] out_row;
        logic [COL_W-1:0] out_col;
        logic             win_last;
        logic             frame_last;
    } tap_info_t;

    function automatic logic [ADDR_W-1:0] pack_pixel_addr(
        input logic [CH_W-1:0]  ch,
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col
    );
        logic [ADDR_W-1:0] a;
        a = '0;
        a[CH_LSB +: CH_W]   = ch;
        a[ROW_LSB +: ROW_W] = row;
        a[0 +: COL_W]       = col;
        return a;
    endfunction

endpackage

// File: rtl/pixel_mem_ctrl_if.sv
// Control, pixel-stream, memory-port and tap-sideband signals of the controller.
interface pixel_mem_ctrl_if;
    import pixel_pkg::*;

    logic              start_load;
    logic              start_conv;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              write_pixel_signal;
    logic [ADDR_W-1:0] write_pixel_addr;
    logic [DATA_W-1:0] write_pixel_data;
    logic              read_pixel_signal;
    logic [ADDR_W-1:0] read_pixel_addr;
    logic              out_ready;
    logic              tap_valid;
    logic [TAP_W-1:0]  tap_idx;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic              win_last;
    logic              frame_last;
    logic              busy;
    logic              done;

    modport slave (
        input  start_load, start_conv, in_valid, in_data, out_ready,
        output in_ready, write_pixel_signal, write_pixel_addr, write_pixel_data,
               read_pixel_signal, read_pixel_addr, tap_valid, tap_idx,
               out_row, out_col, win_last, frame_last, busy, done
    );

    modport master (
        output start_load, start_conv, in_valid, in_data, out_ready,
        input  in_ready, write_pixel_signal, write_pixel_addr, write_pixel_data,
               read_pixel_signal, read_pixel_addr, tap_valid, tap_idx,
               out_row, out_col, win_last, frame_last, busy, done
    );

endinterface

// File: rtl/win_addr_gen.sv
// 3x3 valid-window scan counters (dx, dy, ox, oy innermost first) and read address.
module win_addr_gen
    import pixel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              advance,
    output logic [ADDR_W-1:0] rd_addr,
    output tap_info_t         info
);

    localparam logic [KOFF_W-1:0] K_LAST  = KOFF_W'(K - 1);
    localparam logic [COL_W-1:0]  OX_LAST = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0]  OY_LAST = ROW_W'(OUT_H - 1);

    logic [KOFF_W-1:0] dx_q, dy_q;
    logic [COL_W-1:0]  ox_q;
    logic [ROW_W-1:0]  oy_q;
    logic              dx_wrap, dy_wrap, ox_wrap, oy_wrap;
    logic [ROW_W-1:0]  row_sum;
    logic [COL_W-1:0]  col_sum;

    assign dx_wrap = (dx_q == K_LAST);
    assign dy_wrap = (dy_q == K_LAST);
    assign ox_wrap = (ox_q == OX_LAST);
    assign oy_wrap = (oy_q == OY_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_q <= '0;
            dy_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else if (clr) begin
            dx_q <= '0;
            dy_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else if (advance) begin
            if (!dx_wrap) begin
                dx_q <= dx_q + KOFF_W'(1);
            end else begin
                dx_q <= '0;
                if (!dy_wrap) begin
                    dy_q <= dy_q + KOFF_W'(1);
                end else begin
                    dy_q <= '0;
                    if (!ox_wrap) begin
                        ox_q <= ox_q + COL_W'(1);
                    end else begin
                        ox_q <= '0;
                        oy_q <= oy_wrap ? '0 : oy_q + ROW_W'(1);
                    end
                end
            end
        end
    end

    // Valid-window geometry keeps these 5-bit sums inside the image.
    assign row_sum = oy_q + ROW_W'(dy_q);
    assign col_sum = ox_q + COL_W'(dx_q);

    always_comb begin
        assert ((6'(oy_q) + 6'(dy_q)) <= 6'd31);
        assert ((6'(ox_q) + 6'(dx_q)) <= 6'd31);
    end

    assign rd_addr         = pack_pixel_addr(RED, row_sum, col_sum);
    assign info.tap_idx    = TAP_W'(dy_q) * TAP_W'(3) + TAP_W'(dx_q);
    assign info.out_row    = oy_q;
    assign info.out_col    = ox_q;
    assign info.win_last   = dx_wrap & dy_wrap;
    assign info.frame_last = dx_wrap & dy_wrap & ox_wrap & oy_wrap;

endmodule

// File: rtl/pixel_mem_ctrl.sv
// Sequencer owning both ports of the pixel memory: image load (write) and
// 3x3 window scan (read) with a one-cycle sideband stage matching read latency.
module pixel_mem_ctrl
    import pixel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    pixel_mem_ctrl_if.slave   bus
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [CH_W-1:0]   ch_q;
    logic              beat, load_clr, gen_clr, issue, done_d;
    logic [ADDR_W-1:0] gen_addr;
    tap_info_t         gen_info, tap_q;
    logic              tap_valid_q, done_q;

    win_addr_gen u_win_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (gen_clr),
        .advance (issue),
        .rd_addr (gen_addr),
        .info    (gen_info)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state plus the combinational write/read strobes of the current cycle.
    always_comb begin
        state_d  = state_q;
        beat     = 1'b0;
        load_clr = 1'b0;
        gen_clr  = 1'b0;
        issue    = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_load) begin
                    state_d  = LOAD;
                    load_clr = 1'b1;
                end else if (bus.start_conv) begin
                    state_d = CONV;
                    gen_clr = 1'b1;
                end
            end
            LOAD: begin
                beat = bus.in_valid;
                if (beat && ch_q == CH_LAST && row_q == ROW_LAST && col_q == COL_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            CONV: begin
                issue = bus.out_ready;
                if (issue && gen_info.frame_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load position, col -> row -> ch; wraps to zero after the final beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
        end else if (load_clr) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
        end else if (beat) begin
            col_q <= col_q + COL_W'(1);
            if (col_q == COL_LAST) begin
                row_q <= row_q + ROW_W'(1);
                if (row_q == ROW_LAST) begin
                    ch_q <= (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_valid_q <= 1'b0;
            tap_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            tap_valid_q <= issue;
            tap_q       <= issue ? gen_info : '0;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready           = (state_q == LOAD);
    assign bus.write_pixel_signal = beat;
    assign bus.write_pixel_addr   = beat ? pack_pixel_addr(ch_q, row_q, col_q) : '0;
    assign bus.write_pixel_data   = beat ? bus.in_data : '0;
    assign bus.read_pixel_signal  = issue;
    assign bus.read_pixel_addr    = issue ? gen_addr : '0;
    assign bus.tap_valid          = tap_valid_q;
    assign bus.tap_idx            = tap_q.tap_idx;
    assign bus.out_row            = tap_q.out_row;
    assign bus.out_col            = tap_q.out_col;
    assign bus.win_last           = tap_q.win_last;
    assign bus.frame_last         = tap_q.frame_last;
    assign bus.busy               = (state_q != IDLE);
    assign bus.done               = done_q;

endmodule

// File: tb/tb_pixel_mem_ctrl.sv
// Self-checking bench for pixel_mem_ctrl: load streams, window scans, stalls,
// start collisions and asynchronous reset, against a loop-built reference.
module tb_pixel_mem_ctrl;
    import pixel_pkg::*;

    localparam int NPIX = 3072;
    localparam int NTAP = 8100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pixel_mem_ctrl_if bus ();

    pixel_mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    int e_addr [NTAP];
    int e_tap  [NTAP];
    int e_row  [NTAP];
    int e_col  [NTAP];
    bit e_wl   [NTAP];
    bit e_fl   [NTAP];

    // Expected read order from the scan rules: for oy, ox, dy, dx.
    task automatic build_model();
        int k;
        k = 0;
        for (int oy = 0; oy < 30; oy++)
            for (int ox = 0; ox < 30; ox++)
                for (int dy = 0; dy < 3; dy++)
                    for (int dx = 0; dx < 3; dx++) begin
                        e_addr[k] = (oy + dy) * 32 + (ox + dx);
                        e_tap[k]  = dy * 3 + dx;
                        e_row[k]  = oy;
                        e_col[k]  = ox;
                        e_wl[k]   = (dy == 2 && dx == 2);
                        e_fl[k]   = (dy == 2 && dx == 2 && oy == 29 && ox == 29);
                        k++;
                    end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_chk++;
        if ({bus.in_ready, bus.write_pixel_signal, bus.write_pixel_addr, bus.write_pixel_data,
             bus.read_pixel_signal, bus.read_pixel_addr, bus.tap_valid, bus.tap_idx,
             bus.out_row, bus.out_col, bus.win_last, bus.frame_last, bus.busy, bus.done} !== '0)
            $display("FAIL reset_outputs: busy=%b in_ready=%b tap_valid=%b done=%b, required all 0",
                     bus.busy, bus.in_ready, bus.tap_valid, bus.done);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        n_chk++;
        if ({bus.busy, bus.done, bus.in_ready} !== 3'b000)
            $display("FAIL idle_after_reset: busy/done/in_ready=%b required 000",
                     {bus.busy, bus.done, bus.in_ready});
        else n_pass++;
    endtask

    task automatic test_load_full();
        int bad, ea;
        string msg;
        bad = 0;
        @(negedge clk); bus.start_load = 1'b1;
        @(negedge clk); bus.start_load = 1'b0; #1;
        n_chk++;
        if ({bus.in_ready, bus.busy} !== 2'b11)
            $display("FAIL load_entry: in_ready/busy=%b required 11", {bus.in_ready, bus.busy});
        else n_pass++;
        for (int i = 0; i < NPIX; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i);
            #1;
            ea = ((i / 1024) << 10) | (((i / 32) % 32) << 5) | (i % 32);
            if (bus.write_pixel_signal !== 1'b1 || bus.write_pixel_addr !== 16'(ea) ||
                bus.write_pixel_data !== 16'(i) || bus.read_pixel_signal !== 1'b0) begin
                if (bad == 0)
                    msg = $sformatf("beat %0d we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                                    i, bus.write_pixel_signal, bus.write_pixel_addr,
                                    bus.write_pixel_data, 16'(ea), 16'(i));
                bad++;
            end
            if (i == 0 || i == 1024 || i == NPIX - 1) begin
                n_chk++;
                if (bus.write_pixel_addr !== 16'(ea) || bus.done !== 1'b0)
                    $display("FAIL load_spot_%0d: addr=%h done=%b, required addr=%h done=0",
                             i, bus.write_pixel_addr, bus.done, 16'(ea));
                else n_pass++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0; #1;
        n_chk++;
        if (bad !== 0) $display("FAIL load_stream: %0d bad beats, first: %s", bad, msg);
        else n_pass++;
        n_chk++;
        if ({bus.done, bus.busy, bus.in_ready} !== 3'b100)
            $display("FAIL load_done: done/busy/in_ready=%b required 100",
                     {bus.done, bus.busy, bus.in_ready});
        else n_pass++;
        @(negedge clk); #1;
        n_chk++;
        if (bus.done !== 1'b0) $display("FAIL load_done_pulse: done=%b required 0", bus.done);
        else n_pass++;
    endtask

    task automatic test_conv_scan(input bit rand_ready);
        int  n_iss, n_taps, n_wl, n_fl, n_done, cyc, prev_k, bad_rd, bad_tap;
        bit  rdy, exp_rd, prev_iss;
        string msg_rd, msg_tap;
        n_iss = 0; n_taps = 0; n_wl = 0; n_fl = 0; n_done = 0; cyc = 0;
        prev_k = 0; bad_rd = 0; bad_tap = 0; prev_iss = 1'b0;
        @(negedge clk); bus.start_conv = 1'b1;
        @(negedge clk); bus.start_conv = 1'b0;
        while (!(n_iss == NTAP && !prev_iss) && cyc < 40000) begin
            rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.out_ready = rdy;
            #1;
            exp_rd = rdy && (n_iss < NTAP);
            if (bus.read_pixel_signal !== exp_rd || bus.write_pixel_signal !== 1'b0 ||
                (exp_rd && bus.read_pixel_addr !== 16'(e_addr[n_iss]))) begin
                if (bad_rd == 0)
                    msg_rd = $sformatf("cycle %0d re=%b addr=%h we=%b, required re=%b addr=%h we=0",
                                       cyc, bus.read_pixel_signal, bus.read_pixel_addr,
                                       bus.write_pixel_signal, exp_rd,
                                       exp_rd ? 16'(e_addr[n_iss]) : 16'h0);
                bad_rd++;
            end
            if (bus.tap_valid !== prev_iss ||
                (prev_iss && {bus.tap_idx, bus.out_row, bus.out_col, bus.win_last, bus.frame_last} !==
                 {4'(e_tap[prev_k]), 5'(e_row[prev_k]), 5'(e_col[prev_k]), e_wl[prev_k], e_fl[prev_k]}) ||
                bus.done !== (prev_iss && prev_k == NTAP - 1)) begin
                if (bad_tap == 0)
                    msg_tap = $sformatf("cycle %0d tv=%b tap=%0d row=%0d col=%0d wl=%b fl=%b done=%b, required tv=%b tap=%0d row=%0d col=%0d wl=%b fl=%b",
                                        cyc, bus.tap_valid, bus.tap_idx, bus.out_row, bus.out_col,
                                        bus.win_last, bus.frame_last, bus.done, prev_iss,
                                        e_tap[prev_k], e_row[prev_k], e_col[prev_k],
                                        e_wl[prev_k], e_fl[prev_k]);
                bad_tap++;
            end
            if (bus.tap_valid === 1'b1) n_taps++;
            if (bus.tap_valid === 1'b1 && bus.win_last === 1'b1) n_wl++;
            if (bus.tap_valid === 1'b1 && bus.frame_last === 1'b1) n_fl++;
            if (bus.done === 1'b1) n_done++;
            prev_iss = exp_rd;
            prev_k   = n_iss;
            if (exp_rd) n_iss++;
            cyc++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0; #1;
        n_chk++;
        if (bad_rd !== 0) $display("FAIL conv_issue_r%0d: %0d bad cycles, first: %s", rand_ready, bad_rd, msg_rd);
        else n_pass++;
        n_chk++;
        if (bad_tap !== 0) $display("FAIL conv_tap_r%0d: %0d bad cycles, first: %s", rand_ready, bad_tap, msg_tap);
        else n_pass++;
        n_chk++;
        if (n_taps !== NTAP || n_wl !== 900 || n_fl !== 1 || n_done !== 1)
            $display("FAIL conv_totals_r%0d: taps=%0d win_last=%0d frame_last=%0d done=%0d, required 8100/900/1/1",
                     rand_ready, n_taps, n_wl, n_fl, n_done);
        else n_pass++;
        n_chk++;
        if ({bus.tap_valid, bus.done, bus.busy, bus.read_pixel_signal} !== 4'b0000)
            $display("FAIL conv_idle_r%0d: tv/done/busy/re=%b required 0000", rand_ready,
                     {bus.tap_valid, bus.done, bus.busy, bus.read_pixel_signal});
        else n_pass++;
    endtask

    task automatic test_conv_stall();
        int bad;
        bad = 0;
        @(negedge clk); bus.start_conv = 1'b1;
        @(negedge clk); bus.start_conv = 1'b0;
        for (int k = 0; k < 13; k++) begin
            bus.out_ready = 1'b1; #1;
            if (bus.read_pixel_signal !== 1'b1 || bus.read_pixel_addr !== 16'(e_addr[k])) bad++;
            @(negedge clk);
        end
        for (int s = 0; s < 5; s++) begin
            bus.out_ready = 1'b0; #1;
            if (bus.read_pixel_signal !== 1'b0 || bus.tap_valid !== (s == 0)) bad++;
            @(negedge clk);
        end
        n_chk++;
        if (bad !== 0) $display("FAIL stall_hold: %0d bad cycles, required 0", bad);
        else n_pass++;
        bus.out_ready = 1'b1; #1;
        n_chk++;
        if (bus.read_pixel_signal !== 1'b1 || bus.read_pixel_addr !== 16'h0022)
            $display("FAIL stall_resume: re=%b addr=%h, required re=1 addr=0022",
                     bus.read_pixel_signal, bus.read_pixel_addr);
        else n_pass++;
        @(negedge clk); #1;
        n_chk++;
        if ({bus.tap_valid, bus.tap_idx, bus.out_row, bus.out_col} !== {1'b1, 4'd4, 5'd0, 5'd1})
            $display("FAIL stall_sideband: tv=%b tap=%0d row=%0d col=%0d, required tv=1 tap=4 row=0 col=1",
                     bus.tap_valid, bus.tap_idx, bus.out_row, bus.out_col);
        else n_pass++;
        rst = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_collision_and_bubbles();
        int beats, cyc, bad;
        bit v;
        string msg;
        beats = 0; cyc = 0; bad = 0;
        bus.out_ready = 1'b1;
        @(negedge clk); bus.start_load = 1'b1; bus.start_conv = 1'b1;
        @(negedge clk); bus.start_load = 1'b0; bus.start_conv = 1'b0; #1;
        n_chk++;
        if ({bus.in_ready, bus.busy, bus.read_pixel_signal} !== 3'b110)
            $display("FAIL collision: in_ready/busy/re=%b required 110",
                     {bus.in_ready, bus.busy, bus.read_pixel_signal});
        else n_pass++;
        while (beats < NPIX && cyc < 8000) begin
            v = (cyc % 2 == 0);
            bus.in_valid   = v;
            bus.in_data    = 16'($urandom);
            bus.start_conv = (cyc == 101);
            #1;
            if (bus.write_pixel_signal !== v || bus.read_pixel_signal !== 1'b0 ||
                bus.busy !== 1'b1 || bus.in_ready !== 1'b1 ||
                (v && (bus.write_pixel_addr !== 16'(beats) || bus.write_pixel_data !== bus.in_data))) begin
                if (bad == 0)
                    msg = $sformatf("cycle %0d we=%b addr=%h re=%b busy=%b, required we=%b addr=%h re=0 busy=1",
                                    cyc, bus.write_pixel_signal, bus.write_pixel_addr,
                                    bus.read_pixel_signal, bus.busy, v, 16'(beats));
                bad++;
            end
            if (v) beats++;
            cyc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.start_conv = 1'b0; bus.out_ready = 1'b0; #1;
        n_chk++;
        if (bad !== 0) $display("FAIL bubble_load: %0d bad cycles, first: %s", bad, msg);
        else n_pass++;
        n_chk++;
        if ({bus.done, bus.busy} !== 2'b10)
            $display("FAIL bubble_done: done/busy=%b required 10", {bus.done, bus.busy});
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_conv();
        int bad;
        bad = 0;
        @(negedge clk); bus.start_conv = 1'b1;
        @(negedge clk); bus.start_conv = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #3;
        rst = 1'b1; #1;
        n_chk++;
        if ({bus.in_ready, bus.write_pixel_signal, bus.read_pixel_signal, bus.read_pixel_addr,
             bus.tap_valid, bus.tap_idx, bus.out_row, bus.out_col, bus.win_last,
             bus.frame_last, bus.busy, bus.done} !== '0)
            $display("FAIL rst_mid_conv: tv=%b re=%b busy=%b done=%b tap=%0d, required all 0",
                     bus.tap_valid, bus.read_pixel_signal, bus.busy, bus.done, bus.tap_idx);
        else n_pass++;
        @(negedge clk); #1;
        n_chk++;
        if ({bus.tap_valid, bus.busy, bus.done} !== 3'b000)
            $display("FAIL rst_held: tv/busy/done=%b required 000", {bus.tap_valid, bus.busy, bus.done});
        else n_pass++;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (bus.done !== 1'b0 || bus.read_pixel_signal !== 1'b0) bad++;
        end
        n_chk++;
        if (bad !== 0) $display("FAIL rst_no_done: %0d cycles with done or read, required 0", bad);
        else n_pass++;
        bus.start_conv = 1'b1;
        @(negedge clk); bus.start_conv = 1'b0; #1;
        n_chk++;
        if (bus.read_pixel_signal !== 1'b1 || bus.read_pixel_addr !== 16'h0000)
            $display("FAIL restart_addr: re=%b addr=%h, required re=1 addr=0000",
                     bus.read_pixel_signal, bus.read_pixel_addr);
        else n_pass++;
        @(negedge clk); #1;
        n_chk++;
        if ({bus.tap_valid, bus.tap_idx, bus.out_row, bus.out_col} !== {1'b1, 4'd0, 5'd0, 5'd0})
            $display("FAIL restart_tap: tv=%b tap=%0d row=%0d col=%0d, required 1/0/0/0",
                     bus.tap_valid, bus.tap_idx, bus.out_row, bus.out_col);
        else n_pass++;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time, required completion");
        $fatal(1);
    end

    initial begin
        bus.start_load = 1'b0;
        bus.start_conv = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        build_model();
        test_reset();
        test_load_full();
        test_conv_scan(1'b0);
        test_conv_stall();
        test_collision_and_bubbles();
        test_conv_scan(1'b1);
        test_reset_mid_conv();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pixel_mem_ctrl.md
Name: pixel_mem_ctrl

Overview:
Sequencer that owns both ports of local_mem_pixel. In LOAD it accepts a 32x32x3 image as a channel-major stream of 16-bit pixels over a valid/ready handshake and drives the write port. In CONV it scans a 3x3 valid-convolution window (30x30 outputs) and drives the read port. It emits tap-aligned sideband (tap index, output position, last flags) one cycle after each read issue, matching the 1-cycle SRAM read latency.

Parameters:
IMG_W, 32, image width; column field is 5 bits.
IMG_H, 32, image height; row field is 5 bits.
NUM_CH, 3, channels; channel is encoded in addr[11:10].
K, 3, kernel size; output grid is (IMG_H-K+1) x (IMG_W-K+1) = 30x30.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start_load  in  1  one-cycle pulse; starts an image load
start_conv  in  1  one-cycle pulse; starts a window scan
in_valid  in  1  input pixel valid
in_data  in  16  input pixel
in_ready  out  1  controller accepts a pixel this cycle
write_pixel_signal  out  1  write-port enable to the pixel memory
write_pixel_addr  out  16  {4'b0, ch[1:0], row[4:0], col[4:0]}
write_pixel_data  out  16  pixel forwarded to memory
read_pixel_signal  out  1  read-port enable to the pixel memory
read_pixel_addr  out  16  {6'b0, row[4:0], col[4:0]}
out_ready  in  1  consumer can take the next tap
tap_valid  out  1  read_pixel_data (48b, from memory) is valid this cycle
tap_idx  out  4  0..8, (dy*3+dx) of the current tap
out_row  out  5  output row 0..29 of the current window
out_col  out  5  output column 0..29 of the current window
win_last  out  1  tap 8 of a window
frame_last  out  1  tap 8 of window (29,29)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when LOAD or CONV completes

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: all outputs 0. State is IDLE; all counters are 0.
- States and transitions:
  - IDLE -> LOAD on start_load.
  - IDLE -> CONV on start_conv.
  - Both pulses in the same cycle: LOAD wins and start_conv is dropped.
  - start_* pulses while not IDLE are ignored.
- LOAD:
  - in_ready = 1 throughout LOAD.
  - A beat is in_valid & in_ready. On each beat: write_pixel_signal = 1, write_pixel_data = in_data, write_pixel_addr = {4'b0, ch, row, col}. These are combinational from the beat, so the memory write lands in the same cycle.
  - Counters advance after each beat in the order col -> row -> ch. col wraps 31 -> 0 and increments row; row wraps 31 -> 0 and increments ch.
  - After beat 3072 (ch=2, row=31, col=31): done pulses the next cycle, state returns to IDLE and in_ready drops.
  - in_valid low inserts bubbles with no write.
- CONV issue stage:
  - Issue condition: out_ready & CONV & not finished.
  - When the condition holds: read_pixel_signal = 1, read_pixel_addr = {6'b0, oy+dy, ox+dx}.
  - Iteration order, innermost first: dx, dy, ox, oy. dx and dy run 0..2; ox and oy run 0..29.
  - out_ready low blocks issue with no counter change.
- CONV return stage (1-cycle pipeline register):
  - tap_valid is registered from the issue enable.
  - tap_idx, out_row, out_col, win_last and frame_last are registered alongside it, so they align with read_pixel_data.
  - The consumer must capture data on tap_valid; out_ready throttles only issue.
- CONV completion:
  - After the issue of tap 8 of window (29,29), no further issue occurs.
  - frame_last and tap_valid appear the next cycle. done pulses in that same cycle and state returns to IDLE.
  - Totals: 8100 reads, 900 win_last pulses.
- Address width rule: oy+dy and ox+dx never exceed 31. Use 5-bit sums with no wrap logic; assert oy+dy <= 31 in simulation.
- Port separation: read_pixel_signal is never 1 in LOAD and write_pixel_signal is never 1 in CONV. The ports are physically separate, but the controller guarantees no read-during-write.
- Reset mid-operation: state, counters and the pipeline register clear immediately. Any tap in flight is discarded (tap_valid=0). No done pulse.

Decomposition:
- Shared package pixel_pkg:
  - state enum {IDLE, LOAD, CONV}
  - IMG_W/IMG_H/NUM_CH/K defaults
  - address field localparams: CH_LSB=10, ROW_LSB=5
  - channel codes RED=2'b00, GREEN=2'b01, BLUE=2'b10
  - function pack_pixel_addr(ch, row, col) returning 16 bits
- One sub-module: win_addr_gen (dx/dy/ox/oy counter chain plus address adder, advance input, last flags). The LOAD counter stays inline in the top.

Test Plan:
1. Reset then start_load, stream 3072 beats with in_data = index, in_valid always 1:
   - beat 0 writes addr 0x0000 data 0x0000.
   - beat 1024 writes addr 0x0400 (ch1, 0, 0).
   - beat 3071 writes addr 0x0BFF data 0x0BFF.
   - done pulses 1 cycle after the last beat.
2. LOAD with in_valid toggling 1,0,1,0: writes occur only on valid cycles and addresses stay contiguous. start_conv mid-load is ignored (busy stays 1, no read).
3. CONV with out_ready held 1 after the known load:
   - first reads are 0x0000, 0x0001, 0x0002, 0x0020, ... 0x0042 (win_last on the 9th).
   - tap_valid lags read_pixel_signal by exactly 1 cycle.
   - total 8100 taps; frame_last on read 0x03FF; done coincides.
4. CONV with out_ready low for 5 cycles at tap 4 of window (0,1): no issue during the stall; resumes at 0x0022 with tap_idx=4, out_col=1.
5. start_load and start_conv asserted in the same IDLE cycle: LOAD entered, zero reads, in_ready=1 next cycle.
6. rst asserted mid-CONV with a read in flight: tap_valid=0 while reset is held, all outputs 0, no done pulse. A new start_conv restarts at address 0x0000.
